// File: rtl/result_pkg.sv
// -----------------------------------------------------------------------------
// result_pkg
// Shared definitions for the result scoreboard:
//   - kind_e      : record classification (PROGRESS / WIN / SHARED / DRAW)
//   - MAX_PLAYERS : widest winner mask the classifier accepts
//   - classify()  : combinational classification of a winner mask
//   - leader_w()  : width of the LEADER index for a given player count
// -----------------------------------------------------------------------------
package result_pkg;

   typedef enum logic [1:0] {
      KIND_PROGRESS = 2'd0,
      KIND_WIN      = 2'd1,
      KIND_SHARED   = 2'd2,
      KIND_DRAW     = 2'd3
   } kind_e;

   localparam int MAX_PLAYERS = 8;

   // Bits at or above n_players are ignored, so callers may zero-extend.
   function automatic kind_e classify(input logic [MAX_PLAYERS-1:0] winner,
                                      input int                     n_players);
      int ones;
      ones = 0;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
         if ((i < n_players) && winner[i]) ones++;
      end
      if (ones == 0)              return KIND_PROGRESS;
      else if (ones == 1)         return KIND_WIN;
      else if (ones == n_players) return KIND_DRAW;
      else                        return KIND_SHARED;
   endfunction

   function automatic int leader_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/result_scoreboard_if.sv
// -----------------------------------------------------------------------------
// result_scoreboard_if
// Result input stream and record output stream of the scoreboard.
//   IN_VALID / IN_WINNER / IN_PICK         : one result sample per valid cycle
//   OUT_VALID / OUT_READY                   : record FIFO head handshake
//   OUT_ROUND / OUT_KIND / OUT_WINNER / OUT_PICK : head record fields
// master = producer/consumer side, slave = scoreboard side.
// -----------------------------------------------------------------------------
interface result_scoreboard_if
   import result_pkg::*;
#(
   parameter int N_PLAYERS = 3,
   parameter int RND_W     = 16
) ();

   logic                 IN_VALID;
   logic [N_PLAYERS-1:0] IN_WINNER;
   logic [N_PLAYERS-1:0] IN_PICK;
   logic                 OUT_VALID;
   logic                 OUT_READY;
   logic [RND_W-1:0]     OUT_ROUND;
   kind_e                OUT_KIND;
   logic [N_PLAYERS-1:0] OUT_WINNER;
   logic [N_PLAYERS-1:0] OUT_PICK;

   modport master (
      output IN_VALID, IN_WINNER, IN_PICK, OUT_READY,
      input  OUT_VALID, OUT_ROUND, OUT_KIND, OUT_WINNER, OUT_PICK
   );

   modport slave (
      input  IN_VALID, IN_WINNER, IN_PICK, OUT_READY,
      output OUT_VALID, OUT_ROUND, OUT_KIND, OUT_WINNER, OUT_PICK
   );

endinterface

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Synchronous FIFO with valid/ready read side and 1-cycle write-to-read
// latency.
//   CLK, RST (async, active-high)
//   i_push, i_data        : write request / data (no back-pressure)
//   o_valid, i_ready      : head valid / consumer accept
//   o_data                : head entry
//   o_level               : occupancy
//   o_drop                : push refused this cycle (full, no pop)
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module result_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [WIDTH-1:0]       o_data,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_wr;

   // Extra MSB on each pointer separates full from empty.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop   = !w_empty && i_ready;
   assign w_wr    = i_push && (!w_full || w_pop);

   assign o_valid = !w_empty;
   assign o_data  = r_mem[r_rptr[AW-1:0]];
   assign o_level = r_wptr - r_rptr;
   assign o_drop  = i_push && w_full && !w_pop;

   // When full with a simultaneous pop, the write slot equals the head slot;
   // the head has already been consumed this cycle, so overwriting it is safe.
   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
      end
   end

endmodule

// File: rtl/result_scoreboard.sv
// -----------------------------------------------------------------------------
// result_scoreboard
// Classifies each result sample, keeps saturating per-player win counters,
// a registered leader index and a free-running round number, and queues one
// record {round, kind, winner, pick} per sample in a FIFO.
//   CLK, RST (async, active-high)
//   bus        : result input / record output streams (result_scoreboard_if)
//   CLR_STATS  : synchronous clear of counters, round, leader and overflow
//   WIN_CNT    : packed counters, player i at [i*CNT_W +: CNT_W]
//   LEADER     : lowest index holding the maximum count
//   OVERFLOW   : sticky, a record was dropped on a full FIFO
//   LEVEL      : FIFO occupancy
// -----------------------------------------------------------------------------
module result_scoreboard
   import result_pkg::*;
#(
   parameter int N_PLAYERS = 3,
   parameter int CNT_W     = 8,
   parameter int RND_W     = 16,
   parameter int DEPTH     = 4
) (
   input  logic                            CLK,
   input  logic                            RST,
   result_scoreboard_if.slave              bus,
   input  logic                            CLR_STATS,
   output logic [N_PLAYERS*CNT_W-1:0]      WIN_CNT,
   output logic [leader_w(N_PLAYERS)-1:0]  LEADER,
   output logic                            OVERFLOW,
   output logic [$clog2(DEPTH):0]          LEVEL
);

   localparam int               LDR_W   = leader_w(N_PLAYERS);
   localparam int               REC_W   = RND_W + 2 + 2*N_PLAYERS;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]       r_cnt [N_PLAYERS];
   logic [RND_W-1:0]       r_round;
   logic [LDR_W-1:0]       r_leader;
   logic                   r_overflow;

   logic [MAX_PLAYERS-1:0] w_win_ext;
   kind_e                  w_kind;
   logic                   w_scoring;
   logic [RND_W-1:0]       w_round_base;
   logic [REC_W-1:0]       w_rec_in;
   logic [REC_W-1:0]       w_rec_out;
   logic [1:0]             w_kind_raw;
   logic                   w_drop;
   logic [LDR_W-1:0]       w_best_idx;
   logic [CNT_W-1:0]       w_best_cnt;

   always_comb begin
      w_win_ext                = '0;
      w_win_ext[N_PLAYERS-1:0] = bus.IN_WINNER;
   end

   assign w_kind    = classify(w_win_ext, N_PLAYERS);
   assign w_scoring = bus.IN_VALID && ((w_kind == KIND_WIN) || (w_kind == KIND_SHARED));

   // A clear in the same cycle as a push makes that record carry round 0.
   assign w_round_base = CLR_STATS ? '0 : r_round;
   assign w_rec_in     = {w_round_base, w_kind, bus.IN_WINNER, bus.IN_PICK};

   result_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .i_push  (bus.IN_VALID),
      .i_data  (w_rec_in),
      .o_valid (bus.OUT_VALID),
      .i_ready (bus.OUT_READY),
      .o_data  (w_rec_out),
      .o_level (LEVEL),
      .o_drop  (w_drop)
   );

   assign {bus.OUT_ROUND, w_kind_raw, bus.OUT_WINNER, bus.OUT_PICK} = w_rec_out;
   assign bus.OUT_KIND = kind_e'(w_kind_raw);

   // Round advances on every push attempt, including dropped ones.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_round <= '0;
      else     r_round <= w_round_base + RND_W'(bus.IN_VALID);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < N_PLAYERS; i++) r_cnt[i] <= '0;
      end else if (CLR_STATS) begin
         for (int i = 0; i < N_PLAYERS; i++) r_cnt[i] <= '0;
      end else if (w_scoring) begin
         for (int i = 0; i < N_PLAYERS; i++) begin
            if (bus.IN_WINNER[i] && (r_cnt[i] != CNT_MAX)) r_cnt[i] <= r_cnt[i] + 1'b1;
         end
      end
   end

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      w_best_idx = '0;
      w_best_cnt = r_cnt[0];
      for (int i = 1; i < N_PLAYERS; i++) begin
         if (r_cnt[i] > w_best_cnt) begin
            w_best_cnt = r_cnt[i];
            w_best_idx = LDR_W'(i);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)            r_leader <= '0;
      else if (CLR_STATS) r_leader <= '0;
      else                r_leader <= w_best_idx;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)            r_overflow <= 1'b0;
      else if (CLR_STATS) r_overflow <= 1'b0;
      else if (w_drop)    r_overflow <= 1'b1;
   end

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_cnt
      assign WIN_CNT[g*CNT_W +: CNT_W] = r_cnt[g];
   end

   assign LEADER   = r_leader;
   assign OVERFLOW = r_overflow;

endmodule

// File: tb/tb_result_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_result_scoreboard
// Directed bench for result_scoreboard with N_PLAYERS=3, CNT_W=2, RND_W=2,
// DEPTH=4. A queue-based reference model tracks records, counters, round,
// leader and overflow; a compare process checks the DUT against it on every
// falling edge, and literal expectations pin the model at key points.
// Winner mask bit 0 is player A.
// -----------------------------------------------------------------------------
module tb_result_scoreboard;
   import result_pkg::*;

   localparam int N  = 3;
   localparam int CW = 2;
   localparam int RW = 2;
   localparam int D  = 4;
   localparam int LW = leader_w(N);

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          CLR_STATS = 1'b0;
   logic [N*CW-1:0] WIN_CNT;
   logic [LW-1:0] LEADER;
   logic          OVERFLOW;
   logic [$clog2(D):0] LEVEL;

   result_scoreboard_if #(.N_PLAYERS(N), .RND_W(RW)) bus ();

   result_scoreboard #(
      .N_PLAYERS (N),
      .CNT_W     (CW),
      .RND_W     (RW),
      .DEPTH     (D)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (bus),
      .CLR_STATS (CLR_STATS),
      .WIN_CNT   (WIN_CNT),
      .LEADER    (LEADER),
      .OVERFLOW  (OVERFLOW),
      .LEVEL     (LEVEL)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int round;
      int kind;
      int winner;
      int pick;
   } rec_t;

   rec_t mq[$];
   rec_t m_r;
   int   m_cnt [N];
   int   m_round, m_ovf, m_ldr, m_best, m_nwin;
   bit   m_popd, m_full;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         mq.delete();
         m_round = 0;
         m_ovf   = 0;
         m_ldr   = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
         m_best = 0;
         for (int i = 1; i < N; i++) if (m_cnt[i] > m_cnt[m_best]) m_best = i;
         m_popd = (mq.size() > 0) && bus.OUT_READY;
         m_full = (mq.size() == D);
         if (m_popd) void'(mq.pop_front());
         m_r = '{0, 0, 0, 0};
         if (bus.IN_VALID) begin
            m_nwin     = $countones(bus.IN_WINNER);
            m_r.round  = CLR_STATS ? 0 : m_round;
            m_r.kind   = (m_nwin == 0) ? 0 : (m_nwin == 1) ? 1 : (m_nwin == N) ? 3 : 2;
            m_r.winner = int'(bus.IN_WINNER);
            m_r.pick   = int'(bus.IN_PICK);
            if (!m_full || m_popd) mq.push_back(m_r);
            else                   m_ovf = 1;
            m_round = (m_r.round + 1) % (1 << RW);
         end else if (CLR_STATS) begin
            m_round = 0;
         end
         if (CLR_STATS) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ovf = 0;
            m_ldr = 0;
         end else begin
            m_ldr = m_best;
            if (bus.IN_VALID && (m_r.kind == 1 || m_r.kind == 2)) begin
               for (int i = 0; i < N; i++)
                  if (m_r.winner[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("out_valid", bus.OUT_VALID, mq.size() > 0);
         if (mq.size() > 0) begin
            chk("out_round",  bus.OUT_ROUND,  mq[0].round);
            chk("out_kind",   bus.OUT_KIND,   mq[0].kind);
            chk("out_winner", bus.OUT_WINNER, mq[0].winner);
            chk("out_pick",   bus.OUT_PICK,   mq[0].pick);
         end
         chk("level",    LEVEL,    mq.size());
         chk("overflow", OVERFLOW, m_ovf);
         chk("leader",   LEADER,   m_ldr);
         for (int i = 0; i < N; i++) chk("win_cnt", WIN_CNT[i*CW +: CW], m_cnt[i]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic v, input logic [N-1:0] w, input logic [N-1:0] p,
                      input logic rdy, input logic clr);
      bus.IN_VALID  = v;
      bus.IN_WINNER = w;
      bus.IN_PICK   = p;
      bus.OUT_READY = rdy;
      CLR_STATS     = clr;
      @(posedge CLK);
      #2;
      bus.IN_VALID = 1'b0;
      CLR_STATS    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] wv [5];
      int ek [5];
      int er [5];
      wv = '{3'b001, 3'b010, 3'b011, 3'b111, 3'b000};
      ek = '{1, 1, 2, 3, 0};
      er = '{0, 1, 2, 3, 0};

      bus.IN_VALID  = 1'b0;
      bus.IN_WINNER = '0;
      bus.IN_PICK   = '0;
      bus.OUT_READY = 1'b0;
      #1 RST = 1'b1;
      #1 cmp_en = 1'b1;
      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;
      chk("rst_valid",  bus.OUT_VALID, 0);
      chk("rst_level",  LEVEL, 0);
      chk("rst_cnt",    WIN_CNT, 0);
      chk("rst_leader", LEADER, 0);
      chk("rst_ovf",    OVERFLOW, 0);

      // Classification sequence A, B, AB, ABC, none; round 4 wraps to 0 at RND_W=2.
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, wv[k], N'(k), 1'b1, 1'b0);
         chk("seq_kind",  bus.OUT_KIND,  ek[k]);
         chk("seq_round", bus.OUT_ROUND, er[k]);
      end
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("seq_cnt",    WIN_CNT, 6'b00_10_10);
      chk("seq_leader", LEADER, 0);

      // Overflow: 5 pushes into DEPTH=4 with no reads.
      cyc(1'b0, '0, '0, 1'b1, 1'b1);
      chk("clr_cnt", WIN_CNT, 0);
      for (int k = 0; k < 5; k++) cyc(1'b1, '0, N'(k + 1), 1'b0, 1'b0);
      chk("ovf_level", LEVEL, 4);
      chk("ovf_flag",  OVERFLOW, 1);
      chk("ovf_head",  bus.OUT_ROUND, 0);
      cyc(1'b0, '0, '0, 1'b0, 1'b0);
      chk("stall_pick", bus.OUT_PICK, 1);
      for (int k = 0; k < 4; k++) begin
         chk("drain_round", bus.OUT_ROUND, k);
         chk("drain_pick",  bus.OUT_PICK, k + 1);
         cyc(1'b0, '0, '0, 1'b1, 1'b0);
      end
      chk("drain_empty", bus.OUT_VALID, 0);

      // Full FIFO with simultaneous push and pop.
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) cyc(1'b1, '0, N'(k + 1), 1'b0, 1'b0);
      cyc(1'b1, '0, 3'd7, 1'b1, 1'b0);
      chk("pp_level", LEVEL, 4);
      chk("pp_ovf",   OVERFLOW, 0);
      chk("pp_head",  bus.OUT_PICK, 2);
      repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("pp_tail_pick",  bus.OUT_PICK, 7);
      chk("pp_tail_round", bus.OUT_ROUND, 0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("pp_empty", bus.OUT_VALID, 0);

      // Saturation: B wins 5 times at CNT_W=2.
      cyc(1'b0, '0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) cyc(1'b1, 3'b010, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      chk("sat_cnt",    WIN_CNT, 6'b00_11_00);
      chk("sat_leader", LEADER, 1);

      // Round wrap at RND_W=2.
      cyc(1'b0, '0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, '0, '0, 1'b1, 1'b0);
         chk("wrap_round", bus.OUT_ROUND, er[k]);
      end
      cyc(1'b0, '0, '0, 1'b1, 1'b0);

      // Clear coincident with a push: record carries round 0, counters end at 0.
      cyc(1'b1, 3'b001, '0, 1'b1, 1'b0);
      cyc(1'b1, 3'b001, 3'd5, 1'b1, 1'b1);
      chk("clrpush_round", bus.OUT_ROUND, 0);
      chk("clrpush_pick",  bus.OUT_PICK, 5);
      chk("clrpush_cnt",   WIN_CNT, 0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);

      // Reset mid-operation with three records queued.
      cyc(1'b1, 3'b100, 3'd1, 1'b0, 1'b0);
      cyc(1'b1, 3'b100, 3'd2, 1'b0, 1'b0);
      cyc(1'b1, 3'b000, 3'd3, 1'b0, 1'b0);
      chk("pre_rst_level", LEVEL, 3);
      #1 RST = 1'b1;
      #1;
      chk("mid_rst_valid", bus.OUT_VALID, 0);
      chk("mid_rst_level", LEVEL, 0);
      chk("mid_rst_cnt",   WIN_CNT, 0);
      @(posedge CLK);
      #2 RST = 1'b0;
      cyc(1'b1, 3'b000, 3'd4, 1'b1, 1'b0);
      chk("post_rst_round", bus.OUT_ROUND, 0);
      chk("post_rst_pick",  bus.OUT_PICK, 4);
      chk("post_rst_cnt",   WIN_CNT, 0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
